// File: rtl/icache_ctrl_sequencer_if.sv
// Bundle of the config bus and the icache control handshakes seen by the sequencer.
// The sequencer uses the slave modport; the environment driving it uses master.
interface icache_ctrl_sequencer_if #(
  parameter int ADDR_W     = 5,
  parameter int NB_BYP_ACK = 5
);
  logic                  cfg_req_i;
  logic [ADDR_W-1:0]     cfg_add_i;
  logic                  cfg_wen_i;
  logic [31:0]           cfg_wdata_i;
  logic                  cfg_gnt_o;
  logic                  cfg_r_valid_o;
  logic [31:0]           cfg_r_rdata_o;
  logic                  bypass_req_o;
  logic [NB_BYP_ACK-1:0] bypass_ack_i;
  logic                  flush_req_o;
  logic                  flush_ack_i;
  logic                  sel_flush_req_o;
  logic [31:0]           sel_flush_addr_o;
  logic                  sel_flush_ack_i;
  logic                  ctrl_clear_regs_o;
  logic                  ctrl_enable_regs_o;

  modport slave (
    input  cfg_req_i, cfg_add_i, cfg_wen_i, cfg_wdata_i,
    input  bypass_ack_i, flush_ack_i, sel_flush_ack_i,
    output cfg_gnt_o, cfg_r_valid_o, cfg_r_rdata_o,
    output bypass_req_o, flush_req_o, sel_flush_req_o, sel_flush_addr_o,
    output ctrl_clear_regs_o, ctrl_enable_regs_o
  );

  modport master (
    output cfg_req_i, cfg_add_i, cfg_wen_i, cfg_wdata_i,
    output bypass_ack_i, flush_ack_i, sel_flush_ack_i,
    input  cfg_gnt_o, cfg_r_valid_o, cfg_r_rdata_o,
    input  bypass_req_o, flush_req_o, sel_flush_req_o, sel_flush_addr_o,
    input  ctrl_clear_regs_o, ctrl_enable_regs_o
  );
endinterface

// File: rtl/icache_ctrl_sequencer.sv
// Register-mapped icache control sequencer: turns config-bus writes into one-at-a-time
// bypass / flush / selective-flush handshakes, with timeout abort and sticky error.
module icache_ctrl_sequencer #(
  parameter int NB_BYP_ACK  = 5,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ADDR_W      = 5
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  icache_ctrl_sequencer_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYC > 32'sd0) ? (TIMEOUT_CYC - 32'sd1) : 32'sd0);
  localparam bit TMO_EN = (TIMEOUT_CYC > 32'sd0);

  localparam logic [IDX_W-1:0] IDX_ENABLE    = IDX_W'(32'd0);
  localparam logic [IDX_W-1:0] IDX_FLUSH     = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0] IDX_SEL_FLUSH = IDX_W'(32'd2);
  localparam logic [IDX_W-1:0] IDX_STATUS    = IDX_W'(32'd3);
  localparam logic [IDX_W-1:0] IDX_STAT_CTRL = IDX_W'(32'd4);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BYP_WAIT   = 3'd1,
    ST_FLUSH_WAIT = 3'd2,
    ST_SEL_WAIT   = 3'd3,
    ST_DROP_WAIT  = 3'd4
  } state_e;

  state_e            state_r;
  logic              bypass_req_r;
  logic              flush_req_r;
  logic              sel_req_r;
  logic [31:0]       sel_addr_r;
  logic              drop_sel_r;
  logic [CNT_W-1:0]  tmo_cnt_r;
  logic              err_r;
  logic              enable_r;
  logic              r_valid_r;
  logic [31:0]       rdata_r;
  logic              clear_regs_r;
  logic              enable_regs_r;

  logic [IDX_W-1:0]  idx_s;
  logic              sel_enable_s;
  logic              sel_flush_s;
  logic              sel_sel_s;
  logic              sel_status_s;
  logic              sel_stat_s;
  logic              busy_s;
  logic              gnt_s;
  logic              wr_s;
  logic [31:0]       rdata_s;
  logic              new_byp_s;
  logic              byp_match_s;
  logic              byp_done_s;
  logic              drop_ack_s;
  logic              tmo_hit_s;
  logic              unused_addr_s;

  assign idx_s         = bus.cfg_add_i[ADDR_W-1:2];
  assign unused_addr_s = ^bus.cfg_add_i[1:0];
  assign busy_s        = (state_r != ST_IDLE);
  assign new_byp_s     = ~bus.cfg_wdata_i[0];
  assign byp_match_s   = (bus.bypass_ack_i == {NB_BYP_ACK{new_byp_s}});
  assign byp_done_s    = (bus.bypass_ack_i == {NB_BYP_ACK{bypass_req_r}});
  assign drop_ack_s    = drop_sel_r ? bus.sel_flush_ack_i : bus.flush_ack_i;
  assign tmo_hit_s     = TMO_EN && (tmo_cnt_r == TMO_LAST);
  assign wr_s          = bus.cfg_req_i && !bus.cfg_wen_i && gnt_s;

  // Register decode of the word offset
  always_comb begin
    sel_enable_s = 1'b0;
    sel_flush_s  = 1'b0;
    sel_sel_s    = 1'b0;
    sel_status_s = 1'b0;
    sel_stat_s   = 1'b0;
    case (idx_s)
      IDX_ENABLE:    sel_enable_s = 1'b1;
      IDX_FLUSH:     sel_flush_s  = 1'b1;
      IDX_SEL_FLUSH: sel_sel_s    = 1'b1;
      IDX_STATUS:    sel_status_s = 1'b1;
      IDX_STAT_CTRL: sel_stat_s   = 1'b1;
      default:       sel_stat_s   = 1'b0;
    endcase
  end

  // Operation-launching writes stall until the sequencer is idle; everything else is granted at once
  always_comb begin
    gnt_s = 1'b0;
    if (!bus.cfg_req_i) begin
      gnt_s = 1'b0;
    end else if (bus.cfg_wen_i || !(sel_enable_s || sel_flush_s || sel_sel_s)) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = !busy_s;
    end
  end

  // Read-data mux; writes and unmapped reads return zero
  always_comb begin
    rdata_s = 32'd0;
    if (bus.cfg_wen_i) begin
      case (idx_s)
        IDX_ENABLE: rdata_s = {31'd0, enable_r};
        IDX_STATUS: rdata_s = {29'd0, err_r, ~bypass_req_r, busy_s};
        default:    rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Config-bus response, one cycle after grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_r <= 1'b0;
      rdata_r   <= 32'd0;
    end else begin
      r_valid_r <= bus.cfg_req_i && gnt_s;
      rdata_r   <= (bus.cfg_req_i && gnt_s) ? rdata_s : 32'd0;
    end
  end

  // Statistics control: level enable and single-cycle clear, independent of the FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clear_regs_r  <= 1'b0;
      enable_regs_r <= 1'b0;
    end else begin
      clear_regs_r <= wr_s && sel_stat_s && bus.cfg_wdata_i[1];
      if (wr_s && sel_stat_s) begin
        enable_regs_r <= bus.cfg_wdata_i[0];
      end
    end
  end

  // Sequencer FSM: owns the handshake outputs, the timeout counter and the sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      bypass_req_r <= 1'b1;
      flush_req_r  <= 1'b0;
      sel_req_r    <= 1'b0;
      sel_addr_r   <= 32'd0;
      drop_sel_r   <= 1'b0;
      tmo_cnt_r    <= {CNT_W{1'b0}};
      err_r        <= 1'b0;
      enable_r     <= 1'b0;
    end else begin
      // A timeout in the same cycle overrides the clear below, so the error is never lost
      if (wr_s && sel_status_s && bus.cfg_wdata_i[2]) begin
        err_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          tmo_cnt_r <= {CNT_W{1'b0}};
          if (wr_s && sel_enable_s) begin
            enable_r <= bus.cfg_wdata_i[0];
            if (!((new_byp_s == bypass_req_r) && byp_match_s)) begin
              bypass_req_r <= new_byp_s;
              state_r      <= ST_BYP_WAIT;
            end
          end else if (wr_s && sel_flush_s) begin
            flush_req_r <= 1'b1;
            drop_sel_r  <= 1'b0;
            state_r     <= ST_FLUSH_WAIT;
          end else if (wr_s && sel_sel_s) begin
            sel_addr_r <= bus.cfg_wdata_i;
            sel_req_r  <= 1'b1;
            drop_sel_r <= 1'b1;
            state_r    <= ST_SEL_WAIT;
          end
        end
        ST_BYP_WAIT: begin
          if (byp_done_s) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
            state_r   <= ST_IDLE;
          end else if (tmo_hit_s) begin
            err_r     <= 1'b1;
            tmo_cnt_r <= {CNT_W{1'b0}};
            state_r   <= ST_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1'b1);
          end
        end
        ST_FLUSH_WAIT: begin
          if (bus.flush_ack_i) begin
            flush_req_r <= 1'b0;
            tmo_cnt_r   <= {CNT_W{1'b0}};
            state_r     <= ST_DROP_WAIT;
          end else if (tmo_hit_s) begin
            flush_req_r <= 1'b0;
            err_r       <= 1'b1;
            tmo_cnt_r   <= {CNT_W{1'b0}};
            state_r     <= ST_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1'b1);
          end
        end
        ST_SEL_WAIT: begin
          if (bus.sel_flush_ack_i) begin
            sel_req_r <= 1'b0;
            tmo_cnt_r <= {CNT_W{1'b0}};
            state_r   <= ST_DROP_WAIT;
          end else if (tmo_hit_s) begin
            sel_req_r <= 1'b0;
            err_r     <= 1'b1;
            tmo_cnt_r <= {CNT_W{1'b0}};
            state_r   <= ST_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1'b1);
          end
        end
        ST_DROP_WAIT: begin
          if (!drop_ack_s) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
            state_r   <= ST_IDLE;
          end else if (tmo_hit_s) begin
            err_r     <= 1'b1;
            tmo_cnt_r <= {CNT_W{1'b0}};
            state_r   <= ST_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          flush_req_r <= 1'b0;
          sel_req_r   <= 1'b0;
          tmo_cnt_r   <= {CNT_W{1'b0}};
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_gnt_o          = gnt_s;
  assign bus.cfg_r_valid_o      = r_valid_r;
  assign bus.cfg_r_rdata_o      = rdata_r;
  assign bus.bypass_req_o       = bypass_req_r;
  assign bus.flush_req_o        = flush_req_r;
  assign bus.sel_flush_req_o    = sel_req_r;
  assign bus.sel_flush_addr_o   = sel_addr_r;
  assign bus.ctrl_clear_regs_o  = clear_regs_r;
  assign bus.ctrl_enable_regs_o = enable_regs_r;

endmodule

// File: tb/tb_icache_ctrl_sequencer.sv
// Self-checking bench for icache_ctrl_sequencer: register-level vector table followed by
// hand-written handshake, stall, timeout and reset-mid-operation sequences.
module tb_icache_ctrl_sequencer;

  logic clk;
  logic rst_ni;
  int   checks;
  int   errors;

  icache_ctrl_sequencer_if #(.ADDR_W(5), .NB_BYP_ACK(5)) bus ();

  icache_ctrl_sequencer #(
    .NB_BYP_ACK (5),
    .TIMEOUT_CYC(16),
    .ADDR_W     (5)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One config-bus beat; returns the read data and the number of stalled cycles
  task automatic cfg_op(input logic wen, input logic [4:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int stall);
    @(negedge clk);
    bus.cfg_req_i   = 1'b1;
    bus.cfg_wen_i   = wen;
    bus.cfg_add_i   = addr;
    bus.cfg_wdata_i = wd;
    stall = 0;
    #1;
    while (!bus.cfg_gnt_o && stall < 200) begin
      @(negedge clk);
      #1;
      stall++;
    end
    if (stall >= 200) begin
      check("gnt_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.cfg_req_i   = 1'b0;
    bus.cfg_wen_i   = 1'b1;
    bus.cfg_wdata_i = 32'd0;
    check("r_valid", {31'd0, bus.cfg_r_valid_o}, 32'd1);
    rd = bus.cfg_r_rdata_o;
  endtask

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [4:0]  ack;
    logic [31:0] exp_rdata;
    logic        exp_byp;
    logic        exp_en_regs;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] rd;
  int          st;
  logic [31:0] rd2;
  int          st2;

  initial begin
    checks = 0;
    errors = 0;
    tbl[0]  = '{1'b1, 5'h0C, 32'h0000_0000, 5'h1F, 32'h0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 5'h00, 32'h0000_0000, 5'h1F, 32'h0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 5'h14, 32'h0000_0000, 5'h1F, 32'h0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 5'h10, 32'h0000_0001, 5'h1F, 32'h0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 5'h10, 32'h0000_0000, 5'h1F, 32'h0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 5'h00, 32'h0000_0001, 5'h00, 32'h0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 5'h0C, 32'h0000_0000, 5'h00, 32'h2, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 5'h00, 32'h0000_0000, 5'h00, 32'h1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 5'h00, 32'h0000_0001, 5'h00, 32'h0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 5'h1C, 32'hFFFF_FFFF, 5'h00, 32'h0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 5'h10, 32'h0000_0000, 5'h00, 32'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 5'h00, 32'h0000_0000, 5'h1F, 32'h0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 5'h0F, 32'h0000_0000, 5'h1F, 32'h0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 5'h00, 32'h0000_0000, 5'h1F, 32'h0, 1'b1, 1'b0};

    rst_ni              = 1'b0;
    bus.cfg_req_i       = 1'b0;
    bus.cfg_add_i       = 5'h00;
    bus.cfg_wen_i       = 1'b1;
    bus.cfg_wdata_i     = 32'd0;
    bus.bypass_ack_i    = 5'h1F;
    bus.flush_ack_i     = 1'b0;
    bus.sel_flush_ack_i = 1'b0;

    // Reset state
    #22;
    check("rst_bypass_req", {31'd0, bus.bypass_req_o}, 32'd1);
    check("rst_flush_req", {31'd0, bus.flush_req_o}, 32'd0);
    check("rst_sel_req", {31'd0, bus.sel_flush_req_o}, 32'd0);
    check("rst_sel_addr", bus.sel_flush_addr_o, 32'd0);
    check("rst_clear_regs", {31'd0, bus.ctrl_clear_regs_o}, 32'd0);
    check("rst_enable_regs", {31'd0, bus.ctrl_enable_regs_o}, 32'd0);
    check("rst_r_valid", {31'd0, bus.cfg_r_valid_o}, 32'd0);
    check("rst_rdata", bus.cfg_r_rdata_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Register-level vectors, all issued with the sequencer idle
    for (int i = 0; i < 14; i++) begin
      bus.bypass_ack_i = tbl[i].ack;
      cfg_op(tbl[i].wen, tbl[i].addr, tbl[i].wdata, rd, st);
      check($sformatf("vec%0d_stall", i), st, 32'd0);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("vec%0d_bypass_req", i), {31'd0, bus.bypass_req_o}, {31'd0, tbl[i].exp_byp});
      check($sformatf("vec%0d_enable_regs", i), {31'd0, bus.ctrl_enable_regs_o},
            {31'd0, tbl[i].exp_en_regs});
    end

    // Enable with banks acking three cycles late
    cfg_op(1'b0, 5'h00, 32'h1, rd, st);
    check("en_stall", st, 32'd0);
    check("en_bypass_next", {31'd0, bus.bypass_req_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cfg_op(1'b1, 5'h0C, 32'h0, rd, st);
      check($sformatf("en_status_busy%0d", k), rd, 32'h3);
    end
    bus.bypass_ack_i = 5'h00;
    cfg_op(1'b1, 5'h0C, 32'h0, rd, st);
    check("en_status_last_busy", rd, 32'h3);
    cfg_op(1'b1, 5'h0C, 32'h0, rd, st);
    check("en_status_done", rd, 32'h2);

    // Selective flush with a FLUSH write stalled behind it
    cfg_op(1'b0, 5'h08, 32'h1C00_0040, rd, st);
    check("sel_stall", st, 32'd0);
    check("sel_req_start", {31'd0, bus.sel_flush_req_o}, 32'd1);
    check("sel_addr_start", bus.sel_flush_addr_o, 32'h1C00_0040);
    fork
      begin
        cfg_op(1'b0, 5'h04, 32'h0, rd2, st2);
        check("flush_behind_sel_stall", st2, 32'd6);
      end
      begin
        for (int k = 1; k <= 4; k++) begin
          @(posedge clk);
          #1;
          check($sformatf("sel_req_hold%0d", k), {31'd0, bus.sel_flush_req_o}, 32'd1);
          check($sformatf("sel_addr_hold%0d", k), bus.sel_flush_addr_o, 32'h1C00_0040);
        end
        bus.sel_flush_ack_i = 1'b1;
        @(posedge clk);
        #1;
        check("sel_req_drop", {31'd0, bus.sel_flush_req_o}, 32'd0);
        bus.sel_flush_ack_i = 1'b0;
      end
    join
    check("flush_req_after_stall", {31'd0, bus.flush_req_o}, 32'd1);
    bus.flush_ack_i = 1'b1;
    @(posedge clk);
    #1;
    check("flush_req_drop", {31'd0, bus.flush_req_o}, 32'd0);
    bus.flush_ack_i = 1'b0;
    @(posedge clk);
    #1;
    cfg_op(1'b1, 5'h0C, 32'h0, rd, st);
    check("flush_status_idle", rd, 32'h2);

    // Flush timeout with a stat-control write landing mid-operation
    cfg_op(1'b0, 5'h04, 32'h0, rd, st);
    check("tmo_flush_req", {31'd0, bus.flush_req_o}, 32'd1);
    cfg_op(1'b0, 5'h10, 32'h3, rd, st);
    check("statctl_busy_stall", st, 32'd0);
    check("statctl_clear_pulse", {31'd0, bus.ctrl_clear_regs_o}, 32'd1);
    check("statctl_enable_level", {31'd0, bus.ctrl_enable_regs_o}, 32'd1);
    for (int k = 2; k <= 15; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("tmo_req_hold%0d", k), {31'd0, bus.flush_req_o}, 32'd1);
      if (k == 2) begin
        check("statctl_clear_end", {31'd0, bus.ctrl_clear_regs_o}, 32'd0);
      end
    end
    @(posedge clk);
    #1;
    check("tmo_req_drop", {31'd0, bus.flush_req_o}, 32'd0);
    cfg_op(1'b1, 5'h0C, 32'h0, rd, st);
    check("tmo_status_err", rd, 32'h6);
    cfg_op(1'b0, 5'h0C, 32'h4, rd, st);
    cfg_op(1'b1, 5'h0C, 32'h0, rd, st);
    check("tmo_status_cleared", rd, 32'h2);

    // One bypass bank stuck: bypass never completes and times out
    bus.bypass_ack_i = 5'h0F;
    cfg_op(1'b0, 5'h00, 32'h0, rd, st);
    check("stuck_bypass_req", {31'd0, bus.bypass_req_o}, 32'd1);
    cfg_op(1'b1, 5'h0C, 32'h0, rd, st);
    check("stuck_status_busy", rd, 32'h1);
    repeat (14) @(posedge clk);
    #1;
    cfg_op(1'b1, 5'h0C, 32'h0, rd, st);
    check("stuck_status_last_busy", rd, 32'h1);
    cfg_op(1'b1, 5'h0C, 32'h0, rd, st);
    check("stuck_status_err", rd, 32'h4);
    check("stuck_bypass_held", {31'd0, bus.bypass_req_o}, 32'd1);
    cfg_op(1'b0, 5'h0C, 32'h4, rd, st);
    cfg_op(1'b1, 5'h0C, 32'h0, rd, st);
    check("stuck_status_cleared", rd, 32'h0);

    // Reset asserted while a flush is outstanding
    bus.bypass_ack_i = 5'h1F;
    cfg_op(1'b0, 5'h04, 32'h0, rd, st);
    check("rstmid_flush_req", {31'd0, bus.flush_req_o}, 32'd1);
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    check("rstmid_flush_req_async", {31'd0, bus.flush_req_o}, 32'd0);
    check("rstmid_bypass_req", {31'd0, bus.bypass_req_o}, 32'd1);
    check("rstmid_enable_regs", {31'd0, bus.ctrl_enable_regs_o}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rstmid_flush_stays_low", {31'd0, bus.flush_req_o}, 32'd0);
    cfg_op(1'b1, 5'h0C, 32'h0, rd, st);
    check("rstmid_status", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
